// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP result-packing constants and helpers
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam int STATUS_INEXACT   = 0;
  localparam int STATUS_UNDERFLOW = 1;
  localparam int STATUS_OVERFLOW  = 2;
  localparam int STATUS_INVALID   = 3;

  localparam int ROUND_RNE   = 0;
  localparam int ROUND_TRUNC = 1;

  // Unsigned magnitude of +inf, right-aligned in 64 bits; callers slice to width.
  function automatic logic [63:0] inf_word(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    return inf_word(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_classify.sv
// rtl/fp_round_classify.sv - combinational round, classify and pack of an unpacked FP result
module fp_round_classify
  import fp_pkg::*;
#(
  parameter int EXP_W      = FP_EXP_W,
  parameter int MAN_W      = FP_MAN_W,
  parameter int ROUND_MODE = ROUND_RNE
) (
  input  logic                 sign,
  input  logic [EXP_W+1:0]     exponent,
  input  logic [MAN_W+3:0]     significand,
  input  logic                 nan,
  input  logic                 inf,
  output logic [EXP_W+MAN_W:0] word,
  output logic [3:0]           status
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [63:0] QNAN64 = qnan_word(EXP_W, MAN_W);
  localparam logic [63:0] INF64  = inf_word(EXP_W, MAN_W);
  localparam logic [W-2:0] QNAN_MAG = QNAN64[W-2:0];
  localparam logic [W-2:0] INF_MAG  = INF64[W-2:0];
  localparam logic signed [EXP_W+2:0] E_MAX = signed'({3'b000, {EXP_W{1'b1}}});

  logic                    hidden, lsb, guard_bit, round_bit, sticky_bit;
  logic                    round_up, inexact, carry, is_zero;
  logic [MAN_W+1:0]        sum;
  logic [MAN_W-1:0]        frac_r;
  logic signed [EXP_W+2:0] e_post;

  assign hidden     = significand[MAN_W+3];
  assign lsb        = significand[3];
  assign guard_bit  = significand[2];
  assign round_bit  = significand[1];
  assign sticky_bit = significand[0];

  assign round_up = (ROUND_MODE == ROUND_RNE) ? (guard_bit & (round_bit | sticky_bit | lsb)) : 1'b0;
  assign inexact  = guard_bit | round_bit | sticky_bit;
  assign is_zero  = (significand == '0);

  // One extra bit catches the carry to 2.0; the exponent gets one extra bit so +1 cannot wrap.
  assign sum    = {1'b0, significand[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};
  assign carry  = sum[MAN_W+1];
  assign frac_r = carry ? '0 : sum[MAN_W-1:0];
  assign e_post = signed'({exponent[EXP_W+1], exponent}) + signed'({{(EXP_W+2){1'b0}}, carry});

  always_comb begin
    word   = {sign, e_post[EXP_W-1:0], frac_r};
    status = '0;
    status[STATUS_INEXACT] = inexact;
    if (nan) begin
      word   = {1'b0, QNAN_MAG};
      status = '0;
      status[STATUS_INVALID] = 1'b1;
    end else if (inf) begin
      word   = {sign, INF_MAG};
      status = '0;
    end else if (is_zero) begin
      word   = {sign, {(W-1){1'b0}}};
      status = '0;
    end else if (!e_post[EXP_W+2] && (e_post >= E_MAX)) begin
      word   = {sign, INF_MAG};
      status = '0;
      status[STATUS_OVERFLOW] = 1'b1;
      status[STATUS_INEXACT]  = 1'b1;
    end else if (e_post[EXP_W+2] || (e_post == '0) || !hidden) begin
      word   = {sign, {(W-1){1'b0}}};
      status = '0;
      status[STATUS_UNDERFLOW] = 1'b1;
      status[STATUS_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_result_pack.sv
// rtl/fp_result_pack.sv - FP result rounding/packing stage with 2-entry skid buffer
module fp_result_pack
  import fp_pkg::*;
#(
  parameter int EXP_W      = FP_EXP_W,
  parameter int MAN_W      = FP_MAN_W,
  parameter int ROUND_MODE = ROUND_RNE
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W+1:0]     in_exponent,
  input  logic [MAN_W+3:0]     in_significand,
  input  logic                 in_nan,
  input  logic                 in_inf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] fp_out,
  output logic [3:0]           status
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] rc_word, main_word, skid_word;
  logic [3:0]   rc_status, main_status, skid_status;
  logic         main_valid, skid_valid;
  logic         push, pop;

  fp_round_classify #(
    .EXP_W      (EXP_W),
    .MAN_W      (MAN_W),
    .ROUND_MODE (ROUND_MODE)
  ) u_round_classify (
    .sign        (in_sign),
    .exponent    (in_exponent),
    .significand (in_significand),
    .nan         (in_nan),
    .inf         (in_inf),
    .word        (rc_word),
    .status      (rc_status)
  );

  // in_ready depends only on a flop, so back-pressure never has a combinational path upstream.
  assign in_ready = !skid_valid;
  assign push     = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_word   <= '0;
      main_status <= '0;
      skid_word   <= '0;
      skid_status <= '0;
    end else if (skid_valid) begin
      if (pop) begin
        main_word   <= skid_word;
        main_status <= skid_status;
        skid_valid  <= 1'b0;
      end
    end else if (push) begin
      if (!main_valid || pop) begin
        main_word   <= rc_word;
        main_status <= rc_status;
        main_valid  <= 1'b1;
      end else begin
        skid_word   <= rc_word;
        skid_status <= rc_status;
        skid_valid  <= 1'b1;
      end
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end

  assign out_valid = main_valid;
  assign fp_out    = main_word;
  assign status    = main_status;

endmodule

// File: tb/tb_fp_result_pack.sv
// tb/tb_fp_result_pack.sv - directed self-checking bench for fp_result_pack (single precision)
module tb_fp_result_pack;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exponent = '0;
  logic [26:0] in_significand = '0;
  logic        in_nan = 1'b0;
  logic        in_inf = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] fp_out;
  logic [3:0]  status;
  logic        in_ready_t, out_valid_t;
  logic [31:0] fp_out_t;
  logic [3:0]  status_t;

  int vectors = 0;
  int miscompares = 0;

  fp_result_pack #(.EXP_W(8), .MAN_W(23), .ROUND_MODE(0)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_significand(in_significand),
    .in_nan(in_nan), .in_inf(in_inf), .out_valid(out_valid), .out_ready(out_ready),
    .fp_out(fp_out), .status(status)
  );

  fp_result_pack #(.EXP_W(8), .MAN_W(23), .ROUND_MODE(1)) dut_trunc (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_significand(in_significand),
    .in_nan(in_nan), .in_inf(in_inf), .out_valid(out_valid_t), .out_ready(out_ready),
    .fp_out(fp_out_t), .status(status_t)
  );

  always #5 clock = ~clock;

  task automatic set_beat(input logic s, input logic [9:0] e, input logic [26:0] sig,
                          input logic n, input logic i);
    in_sign = s;
    in_exponent = e;
    in_significand = sig;
    in_nan = n;
    in_inf = i;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (fp_out !== 32'h0) begin miscompares++; $display("FAIL reset_fp_out: got %h want 00000000", fp_out); end
    vectors++;
    if (status !== 4'b0) begin miscompares++; $display("FAIL reset_status: got %b want 0000", status); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_beat(1'b0, 10'd128, 27'h6000000, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || fp_out !== 32'h40400000 || status !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_1p5x2: got v=%b %h/%b want v=1 40400000/0000", out_valid, fp_out, status);
    end
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_rounding();
    logic [26:0] sig_v [3];
    logic [31:0] rne_v [3];
    logic [31:0] trn_v [3];
    sig_v = '{27'h7FFFFFC, 27'h4000004, 27'h4000006};
    rne_v = '{32'h40000000, 32'h3F800000, 32'h3F800001};
    trn_v = '{32'h3FFFFFFF, 32'h3F800000, 32'h3F800000};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_beat(1'b0, 10'd127, sig_v[k], 1'b0, 1'b0);
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || fp_out !== rne_v[k] || status !== 4'b0001) begin
        miscompares++;
        $display("FAIL round_rne[%0d]: got v=%b %h/%b want 1 %h/0001", k, out_valid, fp_out, status, rne_v[k]);
      end
      vectors++;
      if (out_valid_t !== 1'b1 || fp_out_t !== trn_v[k] || status_t !== 4'b0001) begin
        miscompares++;
        $display("FAIL round_trunc[%0d]: got v=%b %h/%b want 1 %h/0001", k, out_valid_t, fp_out_t, status_t, trn_v[k]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_special();
    logic        s_v  [11];
    logic [9:0]  e_v  [11];
    logic [26:0] g_v  [11];
    logic        n_v  [11];
    logic        i_v  [11];
    logic [31:0] rw_v [11];
    logic [3:0]  rs_v [11];
    logic [31:0] tw_v [11];
    logic [3:0]  ts_v [11];
    s_v  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
    e_v  = '{10'd254, 10'd0, 10'd0, 10'd128, 10'd5, 10'h3FD, 10'd1, 10'd300, 10'd254, 10'd1, 10'd255};
    g_v  = '{27'h7FFFFFC, 27'h4000000, 27'h0, 27'h4000000, 27'h0, 27'h4000000,
             27'h0000008, 27'h4000000, 27'h7FFFFF8, 27'h4000000, 27'h4000000};
    n_v  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    i_v  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    rw_v = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000,
             32'h00000000, 32'h7F800000, 32'h7F7FFFFF, 32'h80800000, 32'h7F800000};
    rs_v = '{4'b0101, 4'b0011, 4'b1000, 4'b0000, 4'b0000, 4'b0011,
             4'b0011, 4'b0101, 4'b0000, 4'b0000, 4'b0101};
    tw_v = '{32'h7F7FFFFF, 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000,
             32'h00000000, 32'h7F800000, 32'h7F7FFFFF, 32'h80800000, 32'h7F800000};
    ts_v = '{4'b0001, 4'b0011, 4'b1000, 4'b0000, 4'b0000, 4'b0011,
             4'b0011, 4'b0101, 4'b0000, 4'b0000, 4'b0101};
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      set_beat(s_v[k], e_v[k], g_v[k], n_v[k], i_v[k]);
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || fp_out !== rw_v[k] || status !== rs_v[k]) begin
        miscompares++;
        $display("FAIL special_rne[%0d]: got v=%b %h/%b want 1 %h/%b", k, out_valid, fp_out, status, rw_v[k], rs_v[k]);
      end
      vectors++;
      if (out_valid_t !== 1'b1 || fp_out_t !== tw_v[k] || status_t !== ts_v[k]) begin
        miscompares++;
        $display("FAIL special_trunc[%0d]: got v=%b %h/%b want 1 %h/%b", k, out_valid_t, fp_out_t, status_t, tw_v[k], ts_v[k]);
      end
      @(negedge clock);
    end
    set_beat(1'b0, 10'd0, 27'h0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    int          sent = 0;
    int          rcv = 0;
    int          cyc = 0;
    logic        will;
    logic [31:0] want;
    while ((sent < 8 || rcv < 8) && cyc < 100) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      in_valid = (sent < 8);
      if (sent < 8) set_beat(1'b0, 10'(120 + sent), 27'h4000000 | 27'(sent << 3), 1'b0, 1'b0);
      want = {1'b0, 8'(120 + rcv), 23'(rcv)};
      if (cyc == 3) begin
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
      end
      if (cyc >= 2 && cyc <= 5) begin
        vectors++;
        if (out_valid !== 1'b1 || fp_out !== want || status !== 4'b0000) begin
          miscompares++;
          $display("FAIL bp_hold cyc %0d: got v=%b %h/%b want 1 %h/0000", cyc, out_valid, fp_out, status, want);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (fp_out !== want || status !== 4'b0000) begin
          miscompares++;
          $display("FAIL bp_order beat %0d: got %h/%b want %h/0000", rcv, fp_out, status, want);
        end
        rcv++;
      end
      will = in_valid && (in_ready === 1'b1);
      @(negedge clock);
      cyc++;
      if (will) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (sent != 8 || rcv != 8) begin
      miscompares++;
      $display("FAIL bp_count: got sent=%0d rcv=%0d want 8/8", sent, rcv);
    end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup: got v=%b want 0", out_valid); end
  endtask

  task automatic test_throughput();
    int          p;
    logic [31:0] want;
    out_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      in_valid = (c < 16);
      if (c < 16) begin
        set_beat(c[0], 10'(100 + c), 27'h4000000 | 27'(c << 3), 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL tp_in_ready c=%0d: got %b want 1", c, in_ready); end
      end
      if (c >= 1) begin
        p = c - 1;
        want = {p[0], 8'(100 + p), 23'(p)};
        vectors++;
        if (out_valid !== 1'b1 || fp_out !== want) begin
          miscompares++;
          $display("FAIL tp_beat %0d: got v=%b %h want 1 %h", p, out_valid, fp_out, want);
        end
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL tp_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_beat(1'b0, 10'd130, 27'h4000000, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clock);
    set_beat(1'b0, 10'd131, 27'h4000000, 1'b0, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_full: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
    end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || fp_out !== 32'h0 || status !== 4'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_async: got v=%b %h/%b rdy=%b want 0 00000000/0000 1", out_valid, fp_out, status, in_ready);
    end
    @(negedge clock);
    resetn = 1'b1;
    out_ready = 1'b1;
    set_beat(1'b1, 10'd127, 27'h6000000, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || fp_out !== 32'hBFC00000 || status !== 4'b0000) begin
      miscompares++;
      $display("FAIL ar_first_beat: got v=%b %h/%b want 1 bfc00000/0000", out_valid, fp_out, status);
    end
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_no_stale: got v=%b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rounding();
    test_special();
    test_backpressure();
    test_throughput();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
